serial_frame_tx: RTL
====================

# serial_frame_tx

Framed serial transmitter: accepts one parallel word per valid/ready handshake and shifts it out on a single line as start bit, data bits LSB-first, optional even-parity bit and stop bit. Each bit is held for a fixed number of clocks. It is the transmit end of the team's single-wire framed link and pairs with the framed receiver that samples the same line format. It is built from flip-flop primitives: a bit-period counter, a bit-index counter, a shift register and a small FSM.

## Interface
- CLKS_PER_BIT, 4, clocks per transmitted bit; legal range 1 or more.
- DATA_W, 8, data bits per frame; legal range 1 or more.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits, 0 omits it.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  the producer offers tx_data.
- tx_data  input  DATA_W  word to send; sampled only on the accept edge.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx_line  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- Reset values, applied immediately while rst is high: state IDLE, tx_line=1, tx_ready=1, busy=0, frame_done=0, counters=0, shift register=0.
- Reset mid-frame: the line returns high asynchronously and the word being sent is discarded. No frame_done pulse is produced.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.
- Accept: on a rising edge with tx_valid=1 and tx_ready=1:
  - tx_data is loaded into the shift register.
  - Parity is computed as the XOR of all data bits.
  - The FSM moves to START.
  - tx_data changes after this edge have no effect on the frame.
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY, or → STOP when PARITY_EN=0, after DATA_W bits.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- Line value per state: IDLE=1, START=0, DATA=shift register bit 0, PARITY=even-parity bit, STOP=1.
- Data bits: the shift register moves right by one at each bit boundary. Bit 0 of tx_data is sent first.
- Bit-period counter: width $clog2(CLKS_PER_BIT), minimum 1 bit. It counts from 0 to CLKS_PER_BIT-1 and wraps at each bit boundary. With CLKS_PER_BIT=1 every bit lasts exactly one cycle.
- Bit-index counter: width $clog2(DATA_W+1). It runs from 0 to DATA_W-1 in DATA and is cleared on leaving DATA.
- frame_done: high for exactly the first cycle back in IDLE after a completed STOP.
- In that same cycle tx_ready=1, so a word can be accepted on the next edge. This gives back-to-back frames with exactly one idle-high cycle between the stop and start bits.
- tx_valid is ignored when tx_ready=0; no queuing.

## Timing
- Frame length: (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles. With defaults this is 11 × 4 = 44 cycles.
- Counting cycles from the accept edge:
  - tx_line falls in the cycle immediately after the accept edge.
  - The start bit occupies cycles 1–4.
  - Data bit i occupies cycles 5+4i through 8+4i.
  - Parity occupies cycles 37–40.
  - Stop occupies cycles 41–44.
  - The block is in IDLE in cycle 45, with frame_done=1 and tx_ready=1.
- tx_ready and busy change on the accept edge: tx_ready=0 and busy=1 starting at cycle 1.
- Throughput with continuous tx_valid: one frame per 45 cycles with defaults.

## Test plan
- Reset: assert rst mid-cycle with clk running → tx_line=1, tx_ready=1, busy=0, frame_done=0 immediately, without waiting for a clock edge. Release rst → line stays high with no frame.
- Single frame 0xA5, defaults → line sequence (one value per 4-cycle bit): 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. frame_done pulses once, 45 cycles after the accept edge.
- Odd-weight word 0x07 → parity bit 1. A second run with PARITY_EN=0 → parity slot absent and frame is 40 cycles.
- tx_valid held high with 0x3C then 0xC3 → exactly one idle-high cycle between the frames. tx_data change during frame 1 does not corrupt it. Both frames decode correctly.
- Reset mid-frame: assert rst during data bit 3, then release it and send 0x55 → the aborted frame produces no frame_done, and 0x55 is sent intact.
- CLKS_PER_BIT=1, DATA_W=8 → 0xFF sends as 0,1×8,0(parity),1 over 11 cycles. frame_done follows in cycle 12.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Every bit is held for CLKS_PER_BIT clocks; all outputs are registered.
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              frame_done
);

    // state    | meaning
    // S_IDLE   | line high, ready for a word
    // S_START  | start bit (line low)
    // S_DATA   | data bits, shift register bit 0 on the line
    // S_PARITY | even-parity bit
    // S_STOP   | stop bit (line high)

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [IDX_W-1:0]    w_bit_idx_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_parity;
    logic                w_parity_nxt;
    logic                r_tx_ready;
    logic                r_tx_line;
    logic                r_busy;
    logic                r_frame_done;
    logic                w_line_nxt;
    logic                w_ready_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_bit_end;
    logic                w_last_bit;

    assign w_accept   = tx_valid && r_tx_ready;
    assign w_bit_end  = (r_bit_cnt == CNT_MAX);
    assign w_last_bit = (r_bit_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && w_last_bit) begin
                    w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bit_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        if (r_state == S_IDLE) begin
            if (w_accept) begin
                w_shift_nxt  = tx_data;
                w_parity_nxt = ^tx_data;
            end
        end else begin
            w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + CNT_W'(1);
        end
        if (r_state == S_DATA) begin
            w_bit_idx_nxt = r_bit_idx;
            if (w_bit_end) begin
                w_shift_nxt   = r_shift >> 1;
                w_bit_idx_nxt = w_last_bit ? '0 : r_bit_idx + IDX_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        w_line_nxt  = 1'b1;
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (r_state == S_STOP) && w_bit_end;
        case (w_state_nxt)
            S_START:  w_line_nxt = 1'b0;
            S_DATA:   w_line_nxt = w_shift_nxt[0];
            S_PARITY: w_line_nxt = w_parity_nxt;
            default:  w_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_tx_line    <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_parity     <= w_parity_nxt;
            r_tx_ready   <= w_ready_nxt;
            r_tx_line    <= w_line_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    assign tx_ready   = r_tx_ready;
    assign tx_line    = r_tx_line;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
